game_time_display: RTL and testbench

- Reader side of the game tick counter: consumes the free-running 10-bit game-time count and turns it into decimal digits on the board's 7-segment displays.
- Detects a change in the count, snapshots it and runs an iterative double-dabble (shift-add-3) binary-to-BCD conversion, one bit per clock.
- Latches the BCD result and the segment patterns together and flags each new display value with a one-cycle pulse.
- Sits between the game clock counter and the HEX display pins in the same 10 MHz domain.

---
 rtl/game_time_display_pkg.sv | 34 +++
 rtl/game_time_display_seg7.sv | 24 ++
 rtl/game_time_display.sv | 140 ++++++++++++++
 tb/tb_game_time_display.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_time_display_pkg.sv
// -----------------------------------------------------------------------------
// game_disp_pkg
// Shared definitions for the game-time display reader:
//   - default count width and digit count
//   - conversion FSM state encoding
//   - active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package game_disp_pkg;

   localparam int DEF_WIDTH  = 10;
   localparam int DEF_DIGITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_CODES [0:9] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000    // 9
   };

endpackage

// File: rtl/game_time_display_seg7.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to active-low 7-segment pattern.
// Ports:
//   bcd   in   4  BCD digit (values above 9 show blank)
//   blank in   1  force the digit dark
//   seg   out  7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_decode
   import game_disp_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   // NOTE: default assignment first so every path drives seg; no latch.
   always_comb begin
      seg = SEG_BLANK;
      if (!blank && (bcd <= 4'd9))
         seg = SEG_CODES[bcd];
   end

endmodule

// File: rtl/game_time_display.sv
// -----------------------------------------------------------------------------
// game_time_display
// Watches the free-running game-time count, and whenever it changes converts
// a snapshot to BCD with a bit-serial double-dabble (one bit per clock), then
// latches the BCD digits and their 7-segment patterns together.
// Ports:
//   CLOCK10M     in   1          system clock, rising edge
//   KEY0         in   1          synchronous active-high reset
//   count_in     in   WIDTH      binary game-time count
//   blank_zeros  in   1          suppress leading zero digits
//   bcd_out      out  4*DIGITS   latched BCD, digit 0 = units in [3:0]
//   hex_out      out  7*DIGITS   latched active-low segments, digit i in [7i+6:7i]
//   busy         out  1          conversion in progress
//   update       out  1          one-cycle pulse when bcd_out/hex_out change
// -----------------------------------------------------------------------------
module game_time_display
   import game_disp_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  CLOCK10M,
   input  logic                  KEY0,
   input  logic [WIDTH-1:0]      count_in,
   input  logic                  blank_zeros,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   hex_out,
   output logic                  busy,
   output logic                  update
);

   localparam int BCD_W  = 4*DIGITS;
   localparam int SR_W   = BCD_W + WIDTH;
   localparam int ITER_W = $clog2(WIDTH+1);

   state_t              state, state_nxt;
   logic [SR_W-1:0]     sreg;        // {BCD field, binary field}
   logic [SR_W-1:0]     sreg_step;
   logic [ITER_W-1:0]   iter;
   logic [WIDTH-1:0]    snap;
   logic [WIDTH-1:0]    last_value;
   logic                init_pending;
   logic                start;
   logic [DIGITS-1:0]   digit_blank;
   logic [7*DIGITS-1:0] hex_next;

   // init_pending forces one conversion after reset even if the count equals
   // the reset value of last_value.
   assign start = (count_in != last_value) || init_pending;

   // ---------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLOCK10M) begin
      if (KEY0) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SHIFT;
         ST_SHIFT: if (iter == ITER_W'(WIDTH-1)) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   // ---------------------------------------------------- double-dabble step
   // Adjust every BCD nibble >= 5 by +3, then shift the whole register left.
   always_comb begin
      logic [SR_W-1:0] adj;
      adj = sreg;
      for (int d = 0; d < DIGITS; d++) begin
         if (sreg[WIDTH+4*d +: 4] >= 4'd5)
            adj[WIDTH+4*d +: 4] = sreg[WIDTH+4*d +: 4] + 4'd3;
      end
      sreg_step = {adj[SR_W-2:0], 1'b0};
   end

   // ------------------------------------------------ leading-zero blanking
   // Walk from the top digit down; a digit is dark while no non-zero digit
   // has been seen at or above it. Digit 0 always shows.
   always_comb begin
      logic seen;
      seen        = 1'b0;
      digit_blank = '0;
      for (int d = DIGITS-1; d > 0; d--) begin
         if (sreg[WIDTH+4*d +: 4] != 4'd0) seen = 1'b1;
         digit_blank[d] = blank_zeros && !seen;
      end
   end

   for (genvar d = 0; d < DIGITS; d++) begin : g_dec
      seg7_decode u_dec (
         .bcd   (sreg[WIDTH+4*d +: 4]),
         .blank (digit_blank[d]),
         .seg   (hex_next[7*d +: 7])
      );
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge CLOCK10M) begin
      if (KEY0) begin
         bcd_out      <= '0;
         hex_out      <= {DIGITS{SEG_CODES[0]}};
         update       <= 1'b0;
         init_pending <= 1'b1;
         sreg         <= '0;
         iter         <= '0;
         snap         <= '0;
         last_value   <= '0;
      end else begin
         update <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  snap         <= count_in;
                  sreg         <= {{BCD_W{1'b0}}, count_in};
                  iter         <= '0;
                  init_pending <= 1'b0;
               end
            end
            ST_SHIFT: begin
               sreg <= sreg_step;
               iter <= iter + ITER_W'(1);
            end
            ST_DONE: begin
               bcd_out    <= sreg[SR_W-1 -: BCD_W];
               hex_out    <= hex_next;
               last_value <= snap;
               update     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_game_time_display.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_game_time_display
// Randomized and directed stimulus against a cycle-level reference model that
// tracks the display as "value captured when idle, shown WIDTH+1 edges later".
// -----------------------------------------------------------------------------
module tb_game_time_display;

   localparam int W = 10;
   localparam int D = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [W-1:0]     count_in;
   logic             blank_zeros;
   logic [4*D-1:0]   bcd_out;
   logic [7*D-1:0]   hex_out;
   logic             busy;
   logic             update;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   game_time_display #(.WIDTH(W), .DIGITS(D)) dut (
      .CLOCK10M    (clk),
      .KEY0        (rst),
      .count_in    (count_in),
      .blank_zeros (blank_zeros),
      .bcd_out     (bcd_out),
      .hex_out     (hex_out),
      .busy        (busy),
      .update      (update)
   );

   always #50 clk = ~clk;

   logic [6:0] seg_tab [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_bcd(input int v);
      logic [31:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] exp_hex(input int v, input bit bz);
      logic [31:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         if (bz && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
         else                      r[7*i +: 7] = seg_tab[(v / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   // ------------------------------------------------------ reference model
   int rem = 0;        // edges left until the display changes; 0 = idle
   bit pend = 1'b1;
   int last_v = 0;
   int cap = 0;
   int disp_v = 0;
   bit disp_bz = 1'b0;
   bit m_upd = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         rem = 0; pend = 1'b1; disp_v = 0; disp_bz = 1'b0; m_upd = 1'b0;
      end else if (rem == 0) begin
         m_upd = 1'b0;
         if (pend || int'(count_in) != last_v) begin
            cap = int'(count_in);
            rem = W + 1;
            pend = 1'b0;
         end
      end else begin
         rem--;
         m_upd = 1'b0;
         if (rem == 0) begin
            disp_v  = cap;
            last_v  = cap;
            disp_bz = blank_zeros;
            m_upd   = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         check("busy",   32'(busy),    32'(rem != 0));
         check("update", 32'(update),  32'(m_upd));
         check("bcd",    32'(bcd_out), exp_bcd(disp_v));
         check("hex",    32'(hex_out), exp_hex(disp_v, disp_bz));
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_upd(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (update) begin
            n = i;
            break;
         end
      end
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int n;
      int pulses;

      rst = 1'b1; count_in = '0; blank_zeros = 1'b0;
      tick();
      checking = 1'b1;
      tick();

      // reset release: first conversion of 0
      rst = 1'b0;
      wait_upd(n);
      check("lat_init", 32'(n), 32'd12);
      check("bcd_init", 32'(bcd_out), 32'h0000);
      check("hex_init", 32'(hex_out), {4'h0, {4{7'b1000000}}});

      // maximum value
      count_in = 10'd1023;
      wait_upd(n);
      check("lat_1023", 32'(n), 32'd12);
      check("bcd_1023", 32'(bcd_out), 32'h1023);
      check("hex_1023", 32'(hex_out),
            {4'h0, 7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000});

      // change during SHIFT: two pulses, 5 then 6
      count_in = 10'd5;
      tick();
      repeat (3) tick();
      count_in = 10'd6;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (update) pulses++;
      end
      check("pulses_5_6", 32'(pulses), 32'd2);
      check("bcd_6", 32'(bcd_out), 32'h0006);

      // leading-zero suppression
      blank_zeros = 1'b1;
      count_in = 10'd7;
      wait_upd(n);
      check("hex_bz7", 32'(hex_out), {4'h0, {3{7'b1111111}}, 7'b1111000});
      count_in = 10'd0;
      wait_upd(n);
      check("hex_bz0", 32'(hex_out), {4'h0, {3{7'b1111111}}, 7'b1000000});
      count_in = 10'd100;
      wait_upd(n);
      check("hex_bz100", 32'(hex_out),
            {4'h0, 7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000});

      // reset during the 5th SHIFT cycle
      blank_zeros = 1'b0;
      count_in = 10'd333;
      tick();
      repeat (4) tick();
      rst = 1'b1;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bcd", 32'(bcd_out), 32'h0000);
      check("rst_upd", 32'(update), 32'd0);
      rst = 1'b0;
      wait_upd(n);
      check("lat_after_rst", 32'(n), 32'd12);
      check("bcd_333", 32'(bcd_out), 32'h0333);

      // random changes at random intervals
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) != 0) count_in = W'($urandom_range(0, 1023));
         blank_zeros = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 25)) tick();
      end

      // settle on a non-zero value, then sweep 0..1023
      count_in = 10'd500;
      repeat (30) tick();
      pulses = 0;
      for (int i = 0; i < 1024; i++) begin
         count_in = W'(i);
         blank_zeros = 1'($urandom_range(0, 1));
         repeat (20) begin
            tick();
            if (update) pulses++;
         end
      end
      check("sweep_pulses", 32'(pulses), 32'd1024);
      check("sweep_last", 32'(bcd_out), 32'h1023);

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
